// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared opcode, state, ALUOp and ALUSrcB encodings for the
//               multicycle RISC-V control path and the ALU control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  // Major opcodes, instruction[6:0]
  localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] C_OP_LD    = 7'b0000011;
  localparam logic [6:0] C_OP_SD    = 7'b0100011;
  localparam logic [6:0] C_OP_BEQ   = 7'b1100011;
  localparam logic [6:0] C_OP_ADDI  = 7'b0010011;

  // ALUOp codes handed to the ALU control unit
  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

  // ALU operand B selects
  localparam logic [1:0] C_SRCB_REG    = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR   = 2'b01;
  localparam logic [1:0] C_SRCB_IMM    = 2'b10;
  localparam logic [1:0] C_SRCB_IMMSH1 = 2'b11;

  // Controller states; encodings 11..15 are unused
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_I_EXEC    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  // Full control vector produced by the output decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       illegal;
  } ctrl_t;

  // Dispatch target out of DECODE for a given opcode
  function automatic state_t decode_dispatch(input logic [6:0] op);
    case (op)
      C_OP_LD, C_OP_SD: decode_dispatch = S_MEM_ADDR;
      C_OP_RTYPE:       decode_dispatch = S_R_EXEC;
      C_OP_ADDI:        decode_dispatch = S_I_EXEC;
      C_OP_BEQ:         decode_dispatch = S_BRANCH;
      default:          decode_dispatch = S_TRAP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_output_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_output_decode
// Description : Combinational state -> control vector decoder. Only the
//               FETCH-cycle IR/PC loads depend on the memory ready input.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_ready,
  output ctrl_t  o_ctrl
);

  // Decode the current state into strobes and mux selects; everything defaults to 0
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = C_SRCB_FOUR;
        o_ctrl.alu_op    = C_ALUOP_ADD;
        o_ctrl.ir_write  = i_ready;
        o_ctrl.pc_write  = i_ready;
      end
      S_DECODE: begin
        // branch target computed speculatively into ALUOut
        o_ctrl.alu_src_b = C_SRCB_IMMSH1;
        o_ctrl.alu_op    = C_ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = C_SRCB_IMM;
        o_ctrl.alu_op    = C_ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = C_SRCB_REG;
        o_ctrl.alu_op    = C_ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = C_SRCB_REG;
        o_ctrl.alu_op        = C_ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = 1'b1;
      end
      S_TRAP: begin
        o_ctrl.illegal = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle main control FSM for the RISC-V datapath. Holds
//               the state register and next-state logic; output decoding is
//               delegated to ctrl_output_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_ctrl_raw;
  ctrl_t  w_ctrl;
  logic   w_ready;

  // With waiting disabled every memory access completes in one cycle
  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // State register; reset returns to FETCH and aborts any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; ready only matters in the three memory-access states
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:     w_next_state = w_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next_state = decode_dispatch(opcode);
      S_MEM_ADDR:  w_next_state = (opcode == C_OP_SD) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next_state = w_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next_state = S_FETCH;
      S_MEM_WRITE: w_next_state = w_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next_state = S_ALU_WB;
      S_I_EXEC:    w_next_state = S_ALU_WB;
      S_ALU_WB:    w_next_state = S_FETCH;
      S_BRANCH:    w_next_state = S_FETCH;
      S_TRAP:      w_next_state = S_TRAP;
      default:     w_next_state = S_FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .i_state (r_state),
    .i_ready (w_ready),
    .o_ctrl  (w_ctrl_raw)
  );

  // Reset masks every control output so no write lands in the reset cycle
  assign w_ctrl = reset ? ctrl_t'('0) : w_ctrl_raw;

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign pc_en       = w_ctrl.pc_write | (w_ctrl.pc_write_cond & Zero);
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign illegal     = w_ctrl.illegal;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control unit for the RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the strobes of the register file, data memory and instruction register, and supplies `ALUOp` to the ALU control unit. It sits directly upstream of the ALU control and the `ALU_64bit` datapath, and consumes the ALU `Zero` flag for branch resolution.

## Interface
Parameters:
- `MEM_WAIT_EN`, default 1: when 1, memory states wait on `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 7: instruction[6:0] from the instruction register.
- `Zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory access completes this cycle.
- `PCWrite` output 1: unconditional PC load.
- `PCWriteCond` output 1: PC load if `Zero`.
- `pc_en` output 1: `PCWrite | (PCWriteCond & Zero)`.
- `IorD` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemRead` output 1: memory read strobe.
- `MemWrite` output 1: memory write strobe.
- `IRWrite` output 1: instruction register load.
- `MemtoReg` output 1: write-back select, 0 = ALUOut, 1 = MDR.
- `RegWrite` output 1: register file write.
- `ALUSrcA` output 1: 0 = PC, 1 = register A.
- `ALUSrcB` output 2: 00 = B, 01 = constant 4, 10 = imm, 11 = imm<<1.
- `ALUOp` output 2: 00 = add, 01 = subtract, 10 = funct-decoded.
- `PCSource` output 1: 0 = ALU result, 1 = ALUOut.
- `illegal` output 1: unsupported opcode trapped.
- `state` output 4: current state, for debug.

## Operation
Opcodes:
- R-type 0110011
- ld 0000011
- sd 0100011
- beq 1100011
- addi 0010011

States and transitions:
- FETCH(0): `MemRead=1`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, `ALUOp=00`, `PCSource=0`. `IRWrite` and `PCWrite` are asserted only in the cycle `mem_ready=1`. Stay in FETCH while `mem_ready=0`; otherwise go to DECODE.
- DECODE(1): `ALUSrcA=0`, `ALUSrcB=11`, `ALUOp=00` (branch target into ALUOut). Next state by opcode:
  - ld or sd → MEM_ADDR
  - R-type → R_EXEC
  - addi → I_EXEC
  - beq → BRANCH
  - any other → TRAP
- MEM_ADDR(2): `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=00`. Next is MEM_READ for ld, MEM_WRITE for sd.
- MEM_READ(3): `MemRead=1`, `IorD=1`. Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB(4): `RegWrite=1`, `MemtoReg=1`. Then FETCH.
- MEM_WRITE(5): `MemWrite=1`, `IorD=1`, held while `mem_ready=0`. On `mem_ready`, go to FETCH.
- R_EXEC(6): `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=10`. Then ALU_WB.
- I_EXEC(7): `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=00`. Then ALU_WB.
- ALU_WB(8): `RegWrite=1`, `MemtoReg=0`. Then FETCH.
- BRANCH(9): `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=01`, `PCWriteCond=1`, `PCSource=1`. Then FETCH.
- TRAP(10): all strobes 0, `illegal=1`. Held until `reset`.
- Encodings 11–15 are unreachable. If entered, next state is FETCH with all strobes 0.

Every strobe not listed for a state is 0. Mux selects not listed are 0.

## Timing
- Outputs are Moore-decoded from the state register. Exceptions: `IRWrite`/`PCWrite` in FETCH, and `pc_en`, which also depend on `mem_ready`/`Zero`.
- `reset` high at an edge sets state to FETCH.
- While `reset=1`, every output except `state` is forced to 0, including `illegal`.
- Reset mid-instruction aborts it. No write occurs in the reset cycle.
- Latency with `mem_ready` tied 1:
  - beq: 3 cycles
  - R-type, addi, sd: 4 cycles
  - ld: 5 cycles
- Each cycle with `mem_ready=0` in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- `MemRead`/`MemWrite` stay asserted and stable for the whole wait.
- `mem_ready` is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the opcode constants;
  - the state enumeration (4-bit);
  - the `ALUOp` codes and the `ALUSrcB` select codes.
- The ALU control unit imports the same package.
- One sub-module is natural: `ctrl_output_decode`, a combinational state→control-vector decoder. The parent holds the state register and next-state logic.

## Test plan
- Reset held 2 cycles with `opcode`=0110011 → all strobes 0, `state`=0. Release → `MemRead=1` in the first cycle.
- R-type, `mem_ready`=1 → state sequence 0,1,6,8,0. `RegWrite=1` only in the ALU_WB cycle; `ALUOp=10` in R_EXEC.
- ld with `mem_ready` low for 2 cycles in MEM_READ → sequence 0,1,2,3,3,3,4,0. `MemRead` and `IorD` are steady during the stall.
- beq with `Zero`=1, then again with `Zero`=0 → `pc_en=1` and `PCSource=1` in BRANCH for the first; `pc_en=0` for the second. 3 cycles each.
- `opcode`=1111111 → TRAP, `illegal=1` held for 10 cycles, no strobes. `reset` → FETCH, `illegal=0`.
- sd with `reset` asserted in MEM_WRITE → `MemWrite=0` in that cycle; next state FETCH.
